// File: rtl/mvm_seq_pkg.sv
// Shared constants, state encoding and weight-code helpers for the tt_um_mult sequencer.
package mvm_seq_pkg;

    localparam int IN_LEN        = 14;
    localparam int OUT_LEN       = 7;
    localparam int BIT_WIDTH     = 8;
    localparam int ROWS          = IN_LEN / 2;
    localparam int W_BITS        = 2 * IN_LEN;
    localparam int BYTES_PER_ROW = 6;

    localparam logic [2:0] ROW_PARK      = 3'd7;
    localparam logic [2:0] ROW_LAST      = 3'(ROWS - 1);
    localparam logic [2:0] IDX_LAST      = 3'(OUT_LEN - 1);
    localparam logic [2:0] BYTE_CNT_FULL = 3'(BYTES_PER_ROW);
    localparam logic [2:0] BYTE_CNT_LAST = 3'(BYTES_PER_ROW - 1);

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_BAD  = 2'b10;

    typedef enum logic [1:0] {
        GATHER = 2'd0,
        ISSUE  = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Replace every illegal 2'b10 code by a zero weight.
    function automatic logic [W_BITS-1:0] w_sanitize(input logic [W_BITS-1:0] w);
        logic [W_BITS-1:0] r;
        r = w;
        for (int i = 0; i < IN_LEN; i++) begin
            if (w[2*i +: 2] == W_BAD) begin
                r[2*i +: 2] = W_ZERO;
            end
        end
        return r;
    endfunction

    function automatic logic w_has_bad(input logic [W_BITS-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < IN_LEN; i++) begin
            if (w[2*i +: 2] == W_BAD) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/mvm_seq_outbuf.sv
// Result buffer: captures one pass of multiplier results and streams them out with valid/ready.
module mvm_seq_outbuf
    import mvm_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [2:0]           wr_idx,
    input  logic [BIT_WIDTH-1:0] wr_data,
    input  logic                 set_full,
    output logic                 res_full,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready
);

    logic [BIT_WIDTH-1:0] res_buf [OUT_LEN];
    logic [OUT_LEN-1:0]   wr_sel;
    logic [2:0]           idx_reg;
    logic                 full_reg;
    logic                 fire;

    for (genvar gi = 0; gi < OUT_LEN; gi++) begin : g_sel
        assign wr_sel[gi] = wr_en && (wr_idx == 3'(gi));
    end

    assign fire = full_reg && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_LEN; i++) begin
                res_buf[i] <= '0;
            end
            idx_reg  <= 3'd0;
            full_reg <= 1'b0;
        end else begin
            for (int i = 0; i < OUT_LEN; i++) begin
                if (wr_sel[i]) begin
                    res_buf[i] <= wr_data;
                end
            end
            if (set_full) begin
                full_reg <= 1'b1;
                idx_reg  <= 3'd0;
            end else if (fire) begin
                if (idx_reg == IDX_LAST) begin
                    full_reg <= 1'b0;
                    idx_reg  <= 3'd0;
                end else begin
                    idx_reg <= idx_reg + 3'd1;
                end
            end
        end
    end

    assign res_full  = full_reg;
    assign out_valid = full_reg;
    assign out_last  = full_reg && (idx_reg == IDX_LAST);
    assign out_data  = full_reg ? res_buf[idx_reg] : '0;

endmodule

// File: rtl/tt_um_mult_seq.sv
// Byte-stream sequencer for the ternary matrix-vector multiplier: stages rows, issues them, collects results.
// Optional MVM_SEQ_WCHECK_EN: zeroes illegal 2'b10 weight codes and adds a sticky werr output.
module tt_um_mult_seq
    import mvm_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [BIT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [2:0]             mult_row,
    output logic [W_BITS-1:0]      mult_w,
    output logic [2*BIT_WIDTH-1:0] mult_vec_in,
`ifdef MVM_SEQ_WCHECK_EN
    output logic                   werr,
`endif
    input  logic [BIT_WIDTH-1:0]   mult_vec_out
);

    state_t          state_reg, state_next;
    logic [2:0]      row_reg;
    logic [2:0]      cnt_reg;
    logic [23:0]     w_lo_reg;
    logic [3:0]      w_hi_reg;
    logic [7:0]      x0_reg, x1_reg;
    logic            have_prev_reg, last_reg, live_reg;

    logic            accept, staged_next, row0_block, issuing, row_end, res_full;
    logic [W_BITS-1:0] w_raw, w_drive;

    assign in_ready    = live_reg && (state_reg == GATHER) && (cnt_reg != BYTE_CNT_FULL);
    assign accept      = in_valid && in_ready;
    assign staged_next = (cnt_reg == BYTE_CNT_FULL) || ((cnt_reg == BYTE_CNT_LAST) && accept);
    assign row0_block  = (row_reg == 3'd0) && res_full;
    assign row_end     = (row_reg == ROW_LAST);
    assign w_raw       = {w_hi_reg, w_lo_reg};

    always_comb begin
        state_next = state_reg;
        issuing    = 1'b0;
        unique case (state_reg)
            GATHER: begin
                if (staged_next && !row0_block) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issuing    = 1'b1;
                state_next = (row_end && last_reg) ? FLUSH : GATHER;
            end
            FLUSH: begin
                if (!row0_block) begin
                    issuing = 1'b1;
                    if (row_end) begin
                        state_next = GATHER;
                    end
                end
            end
            default: state_next = GATHER;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= GATHER;
            row_reg       <= 3'd0;
            cnt_reg       <= 3'd0;
            w_lo_reg      <= '0;
            w_hi_reg      <= '0;
            x0_reg        <= '0;
            x1_reg        <= '0;
            have_prev_reg <= 1'b0;
            last_reg      <= 1'b0;
            live_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            live_reg  <= 1'b1;
            if (accept) begin
                cnt_reg <= cnt_reg + 3'd1;
                case (cnt_reg)
                    3'd0:    w_lo_reg[7:0]   <= in_data;
                    3'd1:    w_lo_reg[15:8]  <= in_data;
                    3'd2:    w_lo_reg[23:16] <= in_data;
                    3'd3:    w_hi_reg        <= in_data[3:0];
                    3'd4:    x0_reg          <= in_data;
                    default: x1_reg          <= in_data;
                endcase
                if (in_last) begin
                    last_reg <= 1'b1;
                end
            end else if (state_reg == ISSUE) begin
                cnt_reg <= 3'd0;
            end
            if (issuing) begin
                row_reg <= row_end ? 3'd0 : row_reg + 3'd1;
                // A data pass arms the next collection; a flush pass disarms it.
                if (row_end) begin
                    have_prev_reg <= (state_reg == ISSUE);
                end
            end
            if ((state_reg == ISSUE) && row_end) begin
                last_reg <= 1'b0;
            end
        end
    end

`ifdef MVM_SEQ_WCHECK_EN
    logic werr_reg;
    assign w_drive = w_sanitize(w_raw);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            werr_reg <= 1'b0;
        end else if ((state_reg == ISSUE) && w_has_bad(w_raw)) begin
            werr_reg <= 1'b1;
        end
    end
    assign werr = werr_reg;
`else
    assign w_drive = w_raw;
`endif

    // The multiplier accumulates every edge, so operands are zero outside a data issue.
    assign mult_w      = (state_reg == ISSUE) ? w_drive : '0;
    assign mult_vec_in = (state_reg == ISSUE) ? {x1_reg, x0_reg} : '0;
    assign mult_row    = issuing ? row_reg : ((row_reg == 3'd0) ? ROW_PARK : row_reg);
    assign busy        = (state_reg != GATHER) || (cnt_reg != 3'd0) || (row_reg != 3'd0) || have_prev_reg;

    mvm_seq_outbuf u_outbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (issuing && have_prev_reg),
        .wr_idx    (row_reg),
        .wr_data   (mult_vec_out),
        .set_full  (issuing && row_end && have_prev_reg),
        .res_full  (res_full),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_tt_um_mult_seq.sv
// Self-checking bench for tt_um_mult_seq with a behavioural multiplier and a matrix-vector reference model.
module tb_tt_um_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [2:0]  mult_row;
    logic [27:0] mult_w;
    logic [15:0] mult_vec_in;
    logic [7:0]  mult_vec_out;
`ifdef MVM_SEQ_WCHECK_EN
    logic        werr;
`endif

    always #5 clk = ~clk;

    tt_um_mult_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .mult_row     (mult_row),
        .mult_w       (mult_w),
        .mult_vec_in  (mult_vec_in),
`ifdef MVM_SEQ_WCHECK_EN
        .werr         (werr),
`endif
        .mult_vec_out (mult_vec_out)
    );

    int passed = 0;
    int total  = 0;
    int hazard_cnt = 0;
    int row0_run = 0;
    int out_pos = 0;
    logic [7:0] exp_q [$];
    logic [7:0] pass_b [42];
    string cur_tag = "reset";
    bit ready_mode = 1'b0;
    bit ready_hold = 1'b1;
    bit gap_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Behavioural multiplier: accumulates every edge, row 0 restarts and latches the finished pass.
    int acc [8];
    int lat [8];
    function automatic int wdec_mult(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b11:   return -1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction
    function automatic int contrib(input logic [27:0] w, input logic [15:0] v, input int j);
        return wdec_mult(w[2*j +: 2]) * int'($signed(v[7:0])) + wdec_mult(w[14+2*j +: 2]) * int'($signed(v[15:8]));
    endfunction
    initial begin
        for (int j = 0; j < 8; j++) begin
            acc[j] = 0;
            lat[j] = 0;
        end
    end
    always @(posedge clk) begin
        for (int j = 0; j < 7; j++) begin
            if (mult_row == 3'd0) begin
                lat[j] <= acc[j];
                acc[j] <= contrib(mult_w, mult_vec_in, j);
            end else begin
                acc[j] <= acc[j] + contrib(mult_w, mult_vec_in, j);
            end
        end
    end
    assign mult_vec_out = (mult_row == 3'd0) ? acc[0][7:0] : lat[mult_row][7:0];

    // Reference: y[j] = sum over the 14 inputs of weight(j,i) * x[i], truncated to 8 bits.
    function automatic int wref(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction
    function automatic logic [7:0] ref_elem(input int j);
        int s;
        logic [31:0] w;
        s = 0;
        for (int k = 0; k < 7; k++) begin
            w = {pass_b[6*k+3], pass_b[6*k+2], pass_b[6*k+1], pass_b[6*k]};
            s += wref(w[2*j +: 2]) * int'($signed(pass_b[6*k+4]));
            s += wref(w[14+2*j +: 2]) * int'($signed(pass_b[6*k+5]));
        end
        return s[7:0];
    endfunction

    function automatic logic [7:0] rand_w();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       b[2*i +: 2] = 2'b00;
                1:       b[2*i +: 2] = 2'b01;
                default: b[2*i +: 2] = 2'b11;
            endcase
        end
        return b;
    endfunction

    task automatic build_uniform(input logic [7:0] w, input logic [7:0] x, input logic r3z);
        for (int k = 0; k < 7; k++) begin
            for (int b = 0; b < 4; b++) pass_b[6*k+b] = (r3z && k == 3) ? 8'h00 : w;
            pass_b[6*k+4] = x;
            pass_b[6*k+5] = x;
        end
    endtask

    task automatic build_random();
        for (int k = 0; k < 7; k++) begin
            for (int b = 0; b < 4; b++) pass_b[6*k+b] = rand_w();
            pass_b[6*k+4] = 8'($urandom_range(0, 255));
            pass_b[6*k+5] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic push_const(input logic [7:0] v);
        for (int j = 0; j < 7; j++) exp_q.push_back(v);
    endtask

    task automatic push_model();
        for (int j = 0; j < 7; j++) exp_q.push_back(ref_elem(j));
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit l);
        int n;
        if (gap_en && $urandom_range(0, 3) == 0) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({cur_tag, " in_ready_wait"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_bytes(input int from, input int to, input bit last);
        for (int i = from; i < to; i++) send_byte(pass_b[i], last && (i == 41));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({cur_tag, " drained"}, 32'(exp_q.size()), 32'd0);
        check({cur_tag, " busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst mult_row", 32'(mult_row), 32'd7);
        check("rst mult_w", 32'(mult_w), 32'd0);
        check("rst mult_vec_in", 32'(mult_vec_in), 32'd0);
        exp_q.delete();
        out_pos = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst in_ready_held_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rst in_ready_up", 32'(in_ready), 32'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_hold;
        end
    end

    // Output scoreboard and multiplier-hazard monitor.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mult_row == 3'd0) row0_run++;
            else row0_run = 0;
            if (row0_run > 1) hazard_cnt++;
            if (mult_row == 3'd7 && (mult_w != '0 || mult_vec_in != '0)) hazard_cnt++;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({cur_tag, " spurious_out_valid"}, 32'(out_valid), 32'd0);
                end else begin
                    check({cur_tag, " out_data"}, 32'(out_data), 32'(exp_q.pop_front()));
                    check({cur_tag, " out_last"}, 32'(out_last), 32'(out_pos == 6));
                    out_pos = (out_pos == 6) ? 0 : out_pos + 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] x;
        logic       r3z;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [7];

    initial begin
        vecs[0] = '{w: 8'h55, x: 8'h01, r3z: 1'b0, exp: 8'h0E};
        vecs[1] = '{w: 8'hFF, x: 8'h03, r3z: 1'b0, exp: 8'hD6};
        vecs[2] = '{w: 8'hFF, x: 8'h03, r3z: 1'b1, exp: 8'hDC};
        vecs[3] = '{w: 8'h00, x: 8'h05, r3z: 1'b0, exp: 8'h00};
        vecs[4] = '{w: 8'h55, x: 8'h7F, r3z: 1'b0, exp: 8'hF2};
        vecs[5] = '{w: 8'hFF, x: 8'h80, r3z: 1'b0, exp: 8'h00};
        vecs[6] = '{w: 8'h55, x: 8'hFF, r3z: 1'b0, exp: 8'hF2};

        do_reset();
`ifdef MVM_SEQ_WCHECK_EN
        check("werr after reset", 32'(werr), 32'd0);
`endif

        for (int i = 0; i < 7; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            build_uniform(vecs[i].w, vecs[i].x, vecs[i].r3z);
            push_const(vecs[i].exp);
            send_bytes(0, 42, 1'b1);
            wait_idle();
        end

        cur_tag = "back_to_back";
        build_uniform(8'h55, 8'h01, 1'b0);
        push_const(8'h0E);
        send_bytes(0, 42, 1'b0);
        build_uniform(8'hFF, 8'h02, 1'b0);
        push_const(8'hE4);
        send_bytes(0, 42, 1'b1);
        wait_idle();

        cur_tag = "stall";
        ready_hold = 1'b0;
        build_uniform(8'h55, 8'h01, 1'b0);
        push_const(8'h0E);
        send_bytes(0, 42, 1'b0);
        build_uniform(8'hFF, 8'h01, 1'b0);
        push_const(8'hF2);
        send_bytes(0, 42, 1'b0);
        build_uniform(8'h55, 8'h02, 1'b0);
        push_const(8'h1C);
        send_bytes(0, 6, 1'b0);
        repeat (8) @(negedge clk);
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall mult_row", 32'(mult_row), 32'd7);
        check("stall out_valid", 32'(out_valid), 32'd1);
        check("stall out_data", 32'(out_data), 32'h0E);
        check("stall busy", 32'(busy), 32'd1);
        ready_hold = 1'b1;
        send_bytes(6, 42, 1'b1);
        wait_idle();

        cur_tag = "reset_mid_pass";
        build_uniform(8'hFF, 8'h07, 1'b0);
        send_bytes(0, 27, 1'b0);
        do_reset();
        build_uniform(8'hFF, 8'h02, 1'b0);
        push_const(8'hE4);
        send_bytes(0, 42, 1'b1);
        wait_idle();

        cur_tag = "random";
        ready_mode = 1'b1;
        gap_en = 1'b1;
        for (int p = 0; p < 8; p++) begin
            build_random();
            push_model();
            send_bytes(0, 42, p == 7);
        end
        wait_idle();
        ready_mode = 1'b0;
        gap_en = 1'b0;

`ifdef MVM_SEQ_WCHECK_EN
        cur_tag = "wcheck";
        check("werr before bad weights", 32'(werr), 32'd0);
        build_uniform(8'hAA, 8'h03, 1'b0);
        push_const(8'h00);
        send_bytes(0, 42, 1'b1);
        wait_idle();
        check("werr sticky", 32'(werr), 32'd1);
        do_reset();
        check("werr cleared by reset", 32'(werr), 32'd0);
`endif

        check("multiplier hazards", 32'(hazard_cnt), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
